mult_seq_nxn: RTL and testbench
===============================

MULT_SEQ_NXN -- requirements
Module: mult_seq_nxn

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; must be a multiple of SLICE and at least SLICE.
REQ-002 SHALL have parameter SLICE, default 4: width in bits of the unsigned partial-product multiplier used each cycle.
REQ-003 SHALL define K = WIDTH/SLICE, NPP = K*K and CW = max(1, clog2(NPP)).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_a_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting a new multiply.
REQ-007 dataa  input  WIDTH  unsigned operand A; sampled only on an accepted start.
REQ-008 datab  input  WIDTH  unsigned operand B; sampled only on an accepted start.
REQ-009 product  output  2*WIDTH  registered result of the last completed multiply.
REQ-010 done  output  1  high for exactly one cycle when product is updated.
REQ-011 busy  output  1  high while in state CALC.
REQ-012 err  output  1  high while in state ERR.
REQ-013 state_out  output  3  current state encoding: IDLE=000, CALC=001, DONE=010, ERR=011.
REQ-014 count_out  output  CW  index of the partial product processed this cycle.

Function
REQ-015 Each partial product pp(c), for c = 0..NPP-1, SHALL use a slice index i = c mod K and b slice index j = c div K.
REQ-016 pp(c) SHALL equal A[i*SLICE +: SLICE] * B[j*SLICE +: SLICE], zero-extended and shifted left by (i+j)*SLICE, added into a 2*WIDTH accumulator; no overflow is possible.
REQ-017 In IDLE, when start=1 at an edge, the block SHALL latch dataa/datab, clear the accumulator and count, and enter CALC; otherwise it stays in IDLE.
REQ-018 In CALC, with start=0, each edge SHALL add pp(count) and increment count.
REQ-019 On the edge that adds pp(NPP-1), the block SHALL load product with the final sum, clear count and enter DONE.
REQ-020 Latency: done SHALL be high in the cycle following NPP CALC edges, i.e. NPP+1 edges after start is sampled.
REQ-021 In DONE, done=1; start=1 SHALL launch a new operation exactly as in REQ-017 (back-to-back); start=0 SHALL return the block to IDLE.
REQ-022 start=1 sampled in CALC SHALL abort the operation and enter ERR; the partial sum is discarded and product is unchanged.
REQ-023 In ERR, start=1 SHALL restart the block as in REQ-017; start=0 SHALL keep it in ERR.
REQ-024 product SHALL change only on completion (REQ-019) or on reset; it holds its value in every other state.
REQ-025 dataa/datab changes outside an accepted start SHALL have no effect on the result.
REQ-026 count_out SHALL show count in CALC and 0 in every other state.
REQ-027 Unused state encodings SHALL recover to IDLE on the next edge, with all outputs inactive.

Reset
REQ-028 reset_a_n=0 SHALL immediately force IDLE, with product=0, accumulator=0, count=0, done=0, busy=0, err=0, state_out=000 and count_out=0.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation without asserting done.
REQ-030 The first accepted start SHALL be the first rising edge after reset_a_n deasserts at which start=1.

Verification
REQ-031 Reset during activity -> all outputs 0 and state_out=000 while reset_a_n=0; the same holds when reset is asserted in CALC cycle 2.
REQ-032 WIDTH=8, SLICE=4, A=0xFF, B=0xFF -> busy for 4 cycles, count_out 0,1,2,3, then done=1 and product=0xFE01 on the 5th edge.
REQ-033 WIDTH=8, A=0xA5, B=0x3C -> product=0x26AC; then, with start high in DONE, A=0x00, B=0x7F -> product=0x0000 with no IDLE cycle between the operations.
REQ-034 WIDTH=8, start pulsed again in CALC cycle 2 -> ERR (err=1, state_out=011) with product unchanged; then start with A=3, B=7 -> product=0x0015.
REQ-035 WIDTH=16, SLICE=4, A=0xFFFF, B=0xFFFF -> 16 CALC cycles, then product=0xFFFE0001 and done on the 17th edge.
REQ-036 Randomized WIDTH=8 and WIDTH=12 operands, with the inputs toggled during CALC -> product equals A*B as latched at start.

Source files
------------

// File: rtl/mult_seq_nxn.sv
// Sequential unsigned WIDTHxWIDTH multiplier: one SLICExSLICE partial product
// is accumulated per clock, with start/abort/error handling in a small FSM.
module mult_seq_nxn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4,
  localparam int unsigned K    = WIDTH / SLICE,
  localparam int unsigned NPP  = K * K,
  localparam int unsigned CW   = (NPP > 1) ? $clog2(NPP) : 1
) (
  input  logic                 clk,
  input  logic                 reset_a_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           state_out,
  output logic [CW-1:0]        count_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = 2 * SLICE;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CALC = 3'b001,
    DONE = 3'b010,
    ERR  = 3'b011
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [CW-1:0]     count_q, count_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CW-1:0]     count_out_q, count_out_d;

  int unsigned       idx_a;
  int unsigned       idx_b;
  logic [SLICE-1:0]  a_slice;
  logic [SLICE-1:0]  b_slice;
  logic [SW-1:0]     pp_raw;
  logic [PW-1:0]     pp_shift;
  logic [PW-1:0]     acc_sum;
  logic              last_pp;

  // Partial product for the current count: A slice walks fastest, B slice slowest.
  always_comb begin
    idx_a    = 32'(count_q) % K;
    idx_b    = 32'(count_q) / K;
    a_slice  = a_q[idx_a*SLICE +: SLICE];
    b_slice  = b_q[idx_b*SLICE +: SLICE];
    pp_raw   = SW'(a_slice) * SW'(b_slice);
    pp_shift = PW'(pp_raw) << ((idx_a + idx_b) * SLICE);
    acc_sum  = acc_q + pp_shift;
    last_pp  = (count_q == CW'(NPP - 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (start) begin
          // Abort: partial sum is dropped, product keeps its last value.
          acc_d   = '0;
          count_d = '0;
          state_d = ERR;
        end else if (last_pp) begin
          product_d = acc_sum;
          acc_d     = acc_sum;
          count_d   = '0;
          state_d   = DONE;
        end else begin
          acc_d   = acc_sum;
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase

    done_d      = (state_d == DONE);
    busy_d      = (state_d == CALC);
    err_d       = (state_d == ERR);
    count_out_d = (state_d == CALC) ? count_d : '0;
  end

  always_ff @(posedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      count_out_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      count_q     <= count_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      count_out_q <= count_out_d;
    end
  end

  assign product   = product_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign state_out = state_q;
  assign count_out = count_out_q;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Self-checking bench for mult_seq_nxn: three instances (8/4, 16/4, 12/4)
// with a per-instance queue of expected products.
module tb_mult_seq_nxn;

  logic clk = 1'b0;
  logic reset_a_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [23:0] q12[$];

  logic        start8, done8, busy8, err8;
  logic [7:0]  dataa8, datab8;
  logic [15:0] p8;
  logic [2:0]  st8;
  logic [1:0]  cnt8;

  logic        start16, done16, busy16, err16;
  logic [15:0] dataa16, datab16;
  logic [31:0] p16;
  logic [2:0]  st16;
  logic [3:0]  cnt16;

  logic        start12, done12, busy12, err12;
  logic [11:0] dataa12, datab12;
  logic [23:0] p12;
  logic [2:0]  st12;
  logic [3:0]  cnt12;

  mult_seq_nxn #(.WIDTH(8), .SLICE(4)) u8 (
    .clk(clk), .reset_a_n(reset_a_n), .start(start8), .dataa(dataa8), .datab(datab8),
    .product(p8), .done(done8), .busy(busy8), .err(err8), .state_out(st8), .count_out(cnt8));

  mult_seq_nxn #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .reset_a_n(reset_a_n), .start(start16), .dataa(dataa16), .datab(datab16),
    .product(p16), .done(done16), .busy(busy16), .err(err16), .state_out(st16), .count_out(cnt16));

  mult_seq_nxn #(.WIDTH(12), .SLICE(4)) u12 (
    .clk(clk), .reset_a_n(reset_a_n), .start(start12), .dataa(dataa12), .datab(datab12),
    .product(p12), .done(done12), .busy(busy12), .err(err12), .state_out(st12), .count_out(cnt12));

  // Pulse start for one clock, pushing the expected product; returns at the
  // falling edge of the first CALC cycle.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    dataa8 = a; datab8 = b; start8 = 1'b1;
    q8.push_back(16'(a) * 16'(b));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic launch16(input logic [15:0] a, input logic [15:0] b);
    dataa16 = a; datab16 = b; start16 = 1'b1;
    q16.push_back(32'(a) * 32'(b));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic launch12(input logic [11:0] a, input logic [11:0] b);
    dataa12 = a; datab12 = b; start12 = 1'b1;
    q12.push_back(24'(a) * 24'(b));
    @(negedge clk);
    start12 = 1'b0;
  endtask

  task automatic wait_done8(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    start8 = 1'b0; start16 = 1'b0; start12 = 1'b0;
    dataa8 = '0; datab8 = '0; dataa16 = '0; datab16 = '0; dataa12 = '0; datab12 = '0;
    reset_a_n = 1'b0;
    repeat (2) @(negedge clk);
    obs = {done8, busy8, err8, st8, cnt8, p8};
    n_checks++;
    if (obs !== 24'h0) begin n_fail++; $display("FAIL reset_outputs8 got %h want 000000", obs); end
    n_checks++;
    if ({st16, cnt16, p16, st12, p12} !== '0) begin
      n_fail++; $display("FAIL reset_outputs16_12 st16=%b p16=%h st12=%b p12=%h", st16, p16, st12, p12);
    end
    reset_a_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (st8 !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset got %b want 000", st8); end
  endtask

  task automatic test_ff_latency();
    logic [15:0] exp;
    launch8(8'hFF, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({busy8, done8, cnt8} !== {1'b1, 1'b0, 2'(c)}) begin
        n_fail++; $display("FAIL ff_calc_cycle%0d busy=%b done=%b cnt=%0d want busy=1 done=0 cnt=%0d", c, busy8, done8, cnt8, c);
      end
      @(negedge clk);
    end
    exp = q8.pop_front();
    n_checks++;
    if ({done8, st8, cnt8, p8} !== {1'b1, 3'b010, 2'b00, exp}) begin
      n_fail++; $display("FAIL ff_done done=%b st=%b cnt=%0d product=%h want 1/010/0/%h", done8, st8, cnt8, p8, exp);
    end
    @(negedge clk);
    n_checks++;
    if ({done8, st8, p8} !== {1'b0, 3'b000, 16'hFE01}) begin
      n_fail++; $display("FAIL ff_back_to_idle done=%b st=%b product=%h want 0/000/fe01", done8, st8, p8);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit seen;
    launch8(8'h12, 8'h34);
    @(negedge clk);
    #2 reset_a_n = 1'b0;
    #1;
    n_checks++;
    if ({done8, busy8, err8, st8, cnt8, p8} !== 24'h0) begin
      n_fail++; $display("FAIL reset_mid_calc st=%b busy=%b cnt=%0d product=%h want all zero", st8, busy8, cnt8, p8);
    end
    q8.delete();
    @(negedge clk);
    reset_a_n = 1'b1;
    wait_done8(8, seen);
    n_checks++;
    if (seen || st8 !== 3'b000) begin
      n_fail++; $display("FAIL reset_no_done done_seen=%0d st=%b want 0/000", seen, st8);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [15:0] exp;
    launch8(8'hA5, 8'h3C);
    wait_done8(10, seen);
    exp = q8.pop_front();
    n_checks++;
    if (!seen || p8 !== exp) begin
      n_fail++; $display("FAIL b2b_first done_seen=%0d product=%h want %h", seen, p8, exp);
    end
    launch8(8'h00, 8'h7F);
    n_checks++;
    if ({st8, busy8} !== {3'b001, 1'b1}) begin
      n_fail++; $display("FAIL b2b_no_idle st=%b busy=%b want 001/1", st8, busy8);
    end
    wait_done8(10, seen);
    exp = q8.pop_front();
    n_checks++;
    if (!seen || p8 !== exp) begin
      n_fail++; $display("FAIL b2b_second done_seen=%0d product=%h want %h", seen, p8, exp);
    end
    launch8(8'h12, 8'h34);
    wait_done8(10, seen);
    exp = q8.pop_front();
    n_checks++;
    if (!seen || p8 !== exp) begin
      n_fail++; $display("FAIL op_12x34 done_seen=%0d product=%h want %h", seen, p8, exp);
    end
  endtask

  task automatic test_error();
    bit seen;
    logic [15:0] held;
    logic [15:0] exp;
    held = 16'h12 * 16'h34;
    launch8(8'h55, 8'h66);
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    void'(q8.pop_back());
    n_checks++;
    if ({err8, st8, busy8, done8, p8} !== {1'b1, 3'b011, 1'b0, 1'b0, held}) begin
      n_fail++; $display("FAIL abort_to_err err=%b st=%b busy=%b product=%h want 1/011/0/%h", err8, st8, busy8, p8, held);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({err8, st8, p8} !== {1'b1, 3'b011, held}) begin
      n_fail++; $display("FAIL err_holds err=%b st=%b product=%h want 1/011/%h", err8, st8, p8, held);
    end
    launch8(8'd3, 8'd7);
    wait_done8(10, seen);
    exp = q8.pop_front();
    n_checks++;
    if (!seen || p8 !== exp || exp !== 16'h0015) begin
      n_fail++; $display("FAIL restart_from_err done_seen=%0d product=%h want 0015", seen, p8);
    end
  endtask

  task automatic test_width16();
    logic [31:0] exp;
    launch16(16'hFFFF, 16'hFFFF);
    for (int c = 0; c < 16; c++) begin
      n_checks++;
      if ({busy16, done16, cnt16} !== {1'b1, 1'b0, 4'(c)}) begin
        n_fail++; $display("FAIL w16_calc_cycle%0d busy=%b cnt=%0d want busy=1 cnt=%0d", c, busy16, cnt16, c);
      end
      @(negedge clk);
    end
    exp = q16.pop_front();
    n_checks++;
    if ({done16, st16, p16} !== {1'b1, 3'b010, exp}) begin
      n_fail++; $display("FAIL w16_done done=%b st=%b product=%h want 1/010/%h", done16, st16, p16, exp);
    end
  endtask

  task automatic test_random();
    bit seen;
    logic [15:0] e8;
    logic [23:0] e12;
    for (int n = 0; n < 12; n++) begin
      launch8(8'($urandom), 8'($urandom));
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        dataa8 = 8'($urandom); datab8 = 8'($urandom);
        if (done8) begin seen = 1'b1; break; end
      end
      e8 = q8.pop_front();
      n_checks++;
      if (!seen || p8 !== e8) begin
        n_fail++; $display("FAIL rand8_%0d done_seen=%0d product=%h want %h", n, seen, p8, e8);
      end
    end
    for (int n = 0; n < 12; n++) begin
      launch12(12'($urandom), 12'($urandom));
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        dataa12 = 12'($urandom); datab12 = 12'($urandom);
        if (done12) begin seen = 1'b1; break; end
      end
      e12 = q12.pop_front();
      n_checks++;
      if (!seen || p12 !== e12) begin
        n_fail++; $display("FAIL rand12_%0d done_seen=%0d product=%h want %h", n, seen, p12, e12);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ff_latency();
    test_reset_mid_calc();
    test_back_to_back();
    test_error();
    test_width16();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
